// File: rtl/gauss_window_filter_pkg.sv
// gauss_pkg: binomial kernel weights, normalisation shift, pipeline latency
// and sum-width helper shared by gauss_window_filter and gauss_col_sum.
package gauss_pkg;

    // Cycles from a qualifying input beat to data_out_valid.
    localparam int LATENCY = 3;

    // Binomial weight vectors, 3 bits per tap, tap 0 in the low bits.
    localparam logic [8:0]  GAUSS_W3 = {3'd1, 3'd2, 3'd1};
    localparam logic [14:0] GAUSS_W5 = {3'd1, 3'd4, 3'd6, 3'd4, 3'd1};

    // Total 2-D weight is 2^shift: 16 for K=3, 256 for K=5.
    function automatic int gauss_shift(input int ksize);
        return (ksize == 3) ? 4 : 8;
    endfunction

    // Weight of tap idx of the 1-D kernel.
    function automatic int gauss_weight(input int ksize, input int idx);
        if (ksize == 3) begin
            return int'(GAUSS_W3[idx*3 +: 3]);
        end
        return int'(GAUSS_W5[idx*3 +: 3]);
    endfunction

    // Width of a weighted sum: pixel width plus log2 of the summed weight.
    function automatic int gauss_sum_w(input int data_w, input int frac_bits);
        return data_w + frac_bits;
    endfunction

endpackage

// File: rtl/gauss_window_filter_if.sv
// gauss_window_filter_if: column input beat and filtered pixel output.
// master = column source, slave = filter.
interface gauss_window_filter_if #(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 5
);
    logic                      en;
    logic                      sol;
    logic [KSIZE*DATA_W-1:0]   data_in;
    logic [DATA_W-1:0]         data_out;
    logic                      data_out_valid;

    modport master (
        output en, sol, data_in,
        input  data_out, data_out_valid
    );

    modport slave (
        input  en, sol, data_in,
        output data_out, data_out_valid
    );
endinterface

// File: rtl/gauss_window_filter_col_sum.sv
// gauss_col_sum: registered vertical weighted sum of one KSIZE-pixel column.
// Row 0 (top, oldest) sits in the low slice of col_i.
module gauss_col_sum
    import gauss_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 5
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   en_i,
    input  logic [KSIZE*DATA_W-1:0]                                col_i,
    output logic [gauss_sum_w(DATA_W, gauss_shift(KSIZE)/2)-1:0]   v_o,
    output logic                                                   vld_o
);
    localparam int VW = gauss_sum_w(DATA_W, gauss_shift(KSIZE) / 2);

    logic [VW-1:0] v_d;
    logic [VW-1:0] v_p0_q;
    logic          vld_p0_q;

    // Weighted sum of the rows of the incoming column.
    always_comb begin
        v_d = '0;
        for (int i = 0; i < KSIZE; i++) begin
            v_d = v_d + VW'(gauss_weight(KSIZE, i)) * VW'(col_i[i*DATA_W +: DATA_W]);
        end
    end

    // Stage p0: capture V and its valid on each input beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_p0_q   <= '0;
            vld_p0_q <= 1'b0;
        end else begin
            vld_p0_q <= en_i;
            if (en_i) begin
                v_p0_q <= v_d;
            end
        end
    end

    assign v_o   = v_p0_q;
    assign vld_o = vld_p0_q;

endmodule

// File: rtl/gauss_window_filter.sv
// gauss_window_filter: separable binomial Gaussian (3x3 or 5x5) over a
// stream of vertical columns, with line-start warm-up and a fixed
// three-cycle latency from qualifying beat to data_out_valid.
// Build option: define GAUSS_ROUND_EN for round-half-up normalisation;
// otherwise the result is truncated.
module gauss_window_filter
    import gauss_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gauss_window_filter_if.slave bus
);
    localparam int SHIFT = gauss_shift(KSIZE);
    localparam int VW    = gauss_sum_w(DATA_W, SHIFT / 2);
    localparam int HW    = gauss_sum_w(DATA_W, SHIFT);
    localparam int CW    = $clog2(KSIZE + 1);
`ifdef GAUSS_ROUND_EN
    localparam logic [HW-1:0] ROUND = HW'(1) << (SHIFT - 1);
`else
    localparam logic [HW-1:0] ROUND = '0;
`endif

    if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
        $error("gauss_window_filter: KSIZE must be 3 or 5");
    end
    if (DATA_W < 1 || DATA_W > 12) begin : g_bad_data_w
        $error("gauss_window_filter: DATA_W must be 1..12");
    end

    // Weights sum to 2^SHIFT, so the shifted result always fits DATA_W bits.
    function automatic logic [DATA_W-1:0] normalise(input logic [HW-1:0] h);
        return DATA_W'((h + ROUND) >> SHIFT);
    endfunction

    logic [CW-1:0]     cnt_q, cnt_d;
    logic              qual_d;
    logic              qual_p0_q;
    logic [VW-1:0]     v_p0;
    logic              vld_p0;
    logic [VW-1:0]     win_p1_q [KSIZE];
    logic              qual_p1_q;
    logic [HW-1:0]     h_p1;
    logic [DATA_W-1:0] data_out_p2_q;
    logic              vld_p2_q;

    gauss_col_sum #(
        .DATA_W (DATA_W),
        .KSIZE  (KSIZE)
    ) u_col_sum (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (bus.en),
        .col_i (bus.data_in),
        .v_o   (v_p0),
        .vld_o (vld_p0)
    );

    // Column counter: restart on sol, saturate at KSIZE; a beat qualifies
    // once KSIZE columns of the current line are available.
    always_comb begin
        cnt_d  = cnt_q;
        qual_d = 1'b0;
        if (bus.en) begin
            if (bus.sol) begin
                cnt_d = CW'(1);
            end else if (cnt_q != CW'(KSIZE)) begin
                cnt_d = cnt_q + CW'(1);
            end
            qual_d = (cnt_d == CW'(KSIZE));
        end
    end

    // Stage p0: counter state and qualify flag, aligned with V.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            qual_p0_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            qual_p0_q <= qual_d;
        end
    end

    // Stage p1: V column window, index 0 oldest, advancing only on valid V.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KSIZE; i++) begin
                win_p1_q[i] <= '0;
            end
            qual_p1_q <= 1'b0;
        end else begin
            qual_p1_q <= qual_p0_q;
            if (vld_p0) begin
                for (int i = 0; i < KSIZE - 1; i++) begin
                    win_p1_q[i] <= win_p1_q[i+1];
                end
                win_p1_q[KSIZE-1] <= v_p0;
            end
        end
    end

    // Horizontal weighted sum across the window.
    always_comb begin
        h_p1 = '0;
        for (int j = 0; j < KSIZE; j++) begin
            h_p1 = h_p1 + HW'(gauss_weight(KSIZE, j)) * HW'(win_p1_q[j]);
        end
    end

    // Stage p2: normalised output, held between valid cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_p2_q <= '0;
            vld_p2_q      <= 1'b0;
        end else begin
            vld_p2_q <= qual_p1_q;
            if (qual_p1_q) begin
                data_out_p2_q <= normalise(h_p1);
            end
        end
    end

    assign bus.data_out       = data_out_p2_q;
    assign bus.data_out_valid = vld_p2_q;

endmodule

// File: tb/tb_gauss_window_filter.sv
// Bench for gauss_window_filter: three instances (K=5/8b, K=3/8b, K=5/12b)
// checked every cycle against a direct 2-D convolution model.
module tb_gauss_window_filter;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

`ifdef GAUSS_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    gauss_window_filter_if #(.DATA_W(8),  .KSIZE(5)) bus0 ();
    gauss_window_filter_if #(.DATA_W(8),  .KSIZE(3)) bus1 ();
    gauss_window_filter_if #(.DATA_W(12), .KSIZE(5)) bus2 ();

    gauss_window_filter #(.DATA_W(8),  .KSIZE(5)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    gauss_window_filter #(.DATA_W(8),  .KSIZE(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    gauss_window_filter #(.DATA_W(12), .KSIZE(5)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int pix [5];
    int line_q  [3][$];
    int exp_cyc [3][$];
    int exp_val [3][$];
    int last_v  [3];
    int nout    [3];
    int w5 [5];
    int w3 [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ksz(input int d);
        return (d == 1) ? 3 : 5;
    endfunction

    function automatic int maxv(input int d);
        return (d == 2) ? 4095 : 255;
    endfunction

    function automatic int wt(input int k, input int i);
        return (k == 3) ? w3[i] : w5[i];
    endfunction

    // Reference: full 2-D convolution of the last k columns of the line.
    task automatic model_beat(input int d, input bit s);
        int k, sum, tot, sh;
        k = ksz(d);
        if (s) line_q[d].delete();
        for (int r = 0; r < k; r++) line_q[d].push_back(pix[r]);
        while (line_q[d].size() > k * k) void'(line_q[d].pop_front());
        if (line_q[d].size() == k * k) begin
            sum = 0;
            tot = 0;
            for (int c = 0; c < k; c++) begin
                for (int r = 0; r < k; r++) begin
                    sum += wt(k, c) * wt(k, r) * line_q[d][c*k + r];
                    tot += wt(k, c) * wt(k, r);
                end
            end
            sh = $clog2(tot);
            exp_cyc[d].push_back(cyc + 3);
            exp_val[d].push_back((sum + (RND ? (1 << (sh - 1)) : 0)) >> sh);
        end
    endtask

    task automatic drive(input int d, input bit e, input bit s);
        bus0.en = 1'b0; bus0.sol = 1'b0;
        bus1.en = 1'b0; bus1.sol = 1'b0;
        bus2.en = 1'b0; bus2.sol = 1'b0;
        if (e) begin
            case (d)
                0: begin
                    bus0.en = 1'b1; bus0.sol = s;
                    for (int r = 0; r < 5; r++) bus0.data_in[r*8 +: 8] = 8'(pix[r]);
                end
                1: begin
                    bus1.en = 1'b1; bus1.sol = s;
                    for (int r = 0; r < 3; r++) bus1.data_in[r*8 +: 8] = 8'(pix[r]);
                end
                default: begin
                    bus2.en = 1'b1; bus2.sol = s;
                    for (int r = 0; r < 5; r++) bus2.data_in[r*12 +: 12] = 12'(pix[r]);
                end
            endcase
            model_beat(d, s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1'b0, 1'b0);
    endtask

    task automatic set_pix(input int v);
        for (int r = 0; r < 5; r++) pix[r] = v;
    endtask

    task automatic rand_pix(input int d);
        for (int r = 0; r < 5; r++) pix[r] = int'($urandom_range(maxv(d)));
    endtask

    task automatic expect_eq(input string tag, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Per-cycle output check of one instance against the scheduled model.
    task automatic chk(input int d, input logic v, input logic [11:0] q);
        logic        ev;
        logic [11:0] eq;
        ev = 1'b0;
        if (rst_n !== 1'b1) begin
            last_v[d] = 0;
        end else begin
            while (exp_cyc[d].size() > 0 && exp_cyc[d][0] < cyc) begin
                void'(exp_cyc[d].pop_front());
                void'(exp_val[d].pop_front());
            end
            if (exp_cyc[d].size() > 0 && exp_cyc[d][0] == cyc) begin
                ev = 1'b1;
                void'(exp_cyc[d].pop_front());
                last_v[d] = exp_val[d].pop_front();
            end
        end
        eq = 12'(last_v[d]);
        tests++;
        assert (v === ev) else begin
            fails++;
            $error("FAIL valid[%0d] cyc %0d: got %b, expected %b", d, cyc, v, ev);
        end
        tests++;
        assert (q === eq) else begin
            fails++;
            $error("FAIL data_out[%0d] cyc %0d: got %0d, expected %0d", d, cyc, q, eq);
        end
        if (v === 1'b1) nout[d]++;
    endtask

    always @(negedge clk) begin
        chk(0, bus0.data_out_valid, {4'b0, bus0.data_out});
        chk(1, bus1.data_out_valid, {4'b0, bus1.data_out});
        chk(2, bus2.data_out_valid, bus2.data_out);
    end

    initial begin
        int  n0;
        int  w;
        bit  s0;
        w5 = '{1, 4, 6, 4, 1};
        w3 = '{1, 2, 1};
        cyc = 0; tests = 0; fails = 0;
        for (int d = 0; d < 3; d++) begin last_v[d] = 0; nout[d] = 0; end
        rst_n = 1'b0;
        bus0.en = 1'b0; bus0.sol = 1'b0; bus0.data_in = '0;
        bus1.en = 1'b0; bus1.sol = 1'b0; bus1.data_in = '0;
        bus2.en = 1'b0; bus2.sol = 1'b0; bus2.data_in = '0;
        set_pix(0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        expect_eq("reset_data_out", int'(bus0.data_out), 0);
        expect_eq("reset_valid", int'(bus0.data_out_valid), 0);
        rst_n = 1'b1;
        idle(2);

        // Flat field: sol + 10 beats of 100 -> 6 outputs of 100
        set_pix(100);
        n0 = nout[0];
        drive(0, 1'b1, 1'b1);
        repeat (9) drive(0, 1'b1, 1'b0);
        idle(5);
        expect_eq("flat_count", nout[0] - n0, 6);
        expect_eq("flat_value", int'(bus0.data_out), 100);

        // Impulse K=5: 255 at row 2 of beat 3
        set_pix(0);
        drive(0, 1'b1, 1'b1);
        drive(0, 1'b1, 1'b0);
        pix[2] = 255;
        drive(0, 1'b1, 1'b0);
        set_pix(0);
        drive(0, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b0);
        idle(5);
        expect_eq("impulse_k5", int'(bus0.data_out), RND ? 36 : 35);

        // Impulse K=3: 255 at row 1 of beat 2
        set_pix(0);
        drive(1, 1'b1, 1'b1);
        pix[1] = 255;
        drive(1, 1'b1, 1'b0);
        set_pix(0);
        drive(1, 1'b1, 1'b0);
        idle(5);
        expect_eq("impulse_k3", int'(bus1.data_out), RND ? 64 : 63);

        // Full scale, 8 and 12 bits
        set_pix(255);
        drive(0, 1'b1, 1'b1);
        repeat (5) drive(0, 1'b1, 1'b0);
        idle(5);
        expect_eq("full_scale_8", int'(bus0.data_out), 255);
        set_pix(4095);
        drive(2, 1'b1, 1'b1);
        repeat (5) drive(2, 1'b1, 1'b0);
        idle(5);
        expect_eq("full_scale_12", int'(bus2.data_out), 4095);

        // Bursty flat field: random 0-3 idle cycles between beats
        set_pix(100);
        n0 = nout[0];
        for (int b = 0; b < 10; b++) begin
            drive(0, 1'b1, b == 0);
            repeat ($urandom_range(3)) idle(1);
        end
        idle(5);
        expect_eq("bursty_count", nout[0] - n0, 6);
        expect_eq("bursty_value", int'(bus0.data_out), 100);

        // New sol after beat 3 restarts warm-up
        n0 = nout[0];
        for (int b = 0; b < 3; b++) begin
            rand_pix(0);
            drive(0, 1'b1, b == 0);
            repeat ($urandom_range(3)) idle(1);
        end
        for (int b = 0; b < 5; b++) begin
            rand_pix(0);
            drive(0, 1'b1, b == 0);
            repeat ($urandom_range(3)) idle(1);
        end
        idle(5);
        expect_eq("restart_count", nout[0] - n0, 1);

        // Reset mid-line: pending output is discarded
        set_pix(50);
        drive(0, 1'b1, 1'b1);
        repeat (4) drive(0, 1'b1, 1'b0);
        idle(5);
        expect_eq("pre_reset_value", int'(bus0.data_out), 50);
        set_pix(200);
        drive(0, 1'b1, 1'b1);
        repeat (4) drive(0, 1'b1, 1'b0);
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            line_q[d].delete(); exp_cyc[d].delete(); exp_val[d].delete();
        end
        #1;
        expect_eq("midreset_data_out", int'(bus0.data_out), 0);
        expect_eq("midreset_valid", int'(bus0.data_out_valid), 0);
        n0 = nout[0];
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);
        expect_eq("midreset_no_pending", nout[0] - n0, 0);
        rand_pix(0);
        drive(0, 1'b1, 1'b1);
        for (int b = 0; b < 3; b++) begin rand_pix(0); drive(0, 1'b1, 1'b0); end
        idle(5);
        expect_eq("after_reset_4beats", nout[0] - n0, 0);
        rand_pix(0);
        drive(0, 1'b1, 1'b0);
        idle(5);
        expect_eq("after_reset_beat5", nout[0] - n0, 1);

        // Random lines on every instance
        for (int d = 0; d < 3; d++) begin
            for (int ln = 0; ln < 8; ln++) begin
                w  = int'($urandom_range(12, 1));
                s0 = ($urandom_range(3) != 0);
                for (int b = 0; b < w; b++) begin
                    rand_pix(d);
                    drive(d, 1'b1, (b == 0) ? s0 : 1'b0);
                    repeat ($urandom_range(2)) idle(1);
                end
            end
            idle(5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gauss_window_filter.md
# gauss_window_filter

Parametrised separable Gaussian smoothing filter for the OV5640 video path. The line-buffer stage delivers one KSIZE-pixel vertical column per valid beat. This block builds the KSIZE×KSIZE window, applies a binomial Gaussian kernel (3×3 or 5×5), normalises the result and emits one filtered pixel per qualifying beat. Unlike the bare window register it replaces, it supports multi-bit pixels and line-start warm-up, and it produces a valid-qualified output.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits (1..12)
- KSIZE, 5, kernel size; legal values 3 or 5, anything else is an elaboration error

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  input column valid; one beat per cycle it is high
- sol  in  1  start of line; sampled only when en=1, marks that beat as column 1 of a new line
- data_in  in  KSIZE*DATA_W  column pixels; slice [DATA_W-1:0] is the top (oldest) row, the highest slice is the bottom row
- data_out  out  DATA_W  filtered centre pixel
- data_out_valid  out  1  data_out qualifier, one cycle per output

## Operation
- Kernel weights: K=5 uses [1 4 6 4 1] per axis, total weight 256, shift 8. K=3 uses [1 2 1], total 16, shift 4.
- Vertical pass: on each en beat, V = Σ w_i·row_i, width DATA_W+SHIFT/2. The V values of the last KSIZE beats are kept in a column shift register that advances only on valid V.
- Horizontal pass: H = Σ w_j·V_j, width DATA_W+SHIFT, oldest column weighted w_0.
- Normalise: data_out = (H + ROUND) >> SHIFT. Since the weights sum to 2^SHIFT, the result never exceeds 2^DATA_W−1, so no saturation logic is present.
- Warm-up: a column counter is set to 1 on an en beat with sol=1, increments on each other en beat, and saturates at KSIZE.
  - An output is produced for every en beat at which the counter, after update, equals KSIZE.
  - A line of W beats yields W−KSIZE+1 outputs.
  - Each output is centred on beat n−(KSIZE−1)/2.
- sol with en=0 is ignored. An en beat before any sol after reset counts as a continuation of the current line; the counter starts at 0 after reset.
- A new sol mid-pipeline restarts warm-up only. Outputs already in flight from the previous line still emerge with their normal latency, and columns from the two lines are never combined into one output.
- Row and frame edges are not padded. Top and bottom handling belongs to the line buffer.

## Timing
- Fixed latency: data_out_valid rises exactly 3 cycles after the qualifying en beat (beat at cycle T, output at T+3). It is high for one cycle, with data_out stable in that cycle.
- Fully pipelined, with no backpressure. Back-to-back en beats give back-to-back outputs, and gaps in en give matching gaps in the output.
- data_out holds its last value when data_out_valid=0.
- Reset: data_out=0, data_out_valid=0, counter=0, all window, V and pipeline registers=0. Reset asserted mid-line discards all in-flight outputs. After release, a sol plus KSIZE beats are required before the next output.

## Configuration
- GAUSS_ROUND_EN defined: ROUND = 2^(SHIFT−1), giving round-half-up.
- GAUSS_ROUND_EN undefined: ROUND = 0, giving truncation.
- Latency and widths are identical in both builds.

## Structure
- Package gauss_pkg holds:
  - the weight vectors for K=3 and K=5
  - a SHIFT function of KSIZE
  - the LATENCY constant (3)
  - a width helper for the V and H sums
- One sub-module, gauss_col_sum: the registered vertical weighted sum of one column, parametrised by DATA_W and KSIZE. It is instantiated once, and the top level owns the counter, V shift register, horizontal sum and normalisation.

## Test plan
- Flat field: K=5, DATA_W=8, all pixels 100, sol plus 10 consecutive beats → 6 outputs of 100, the first at 3 cycles after beat 5, the last 3 cycles after beat 10.
- Impulse: K=5, a single 255 at row 2 of beat 3 of a 5-beat line, all other pixels 0 → the output at beat 5 is 36 with GAUSS_ROUND_EN, 35 without it.
- Impulse: K=3, a single 255 at row 1 of beat 2 of a 3-beat line → the output is 64 with rounding, 63 without.
- Full scale: all pixels 255, DATA_W=8 and DATA_W=12 (4095) → outputs equal full scale, with no wrap.
- Bursty en: the flat-field line from the first scenario delivered with random 0–3 idle cycles between beats → identical 6 outputs, each exactly 3 cycles after its beat. A new sol after beat 3 restarts warm-up, with no output until beat 5 of the new line.
- Reset mid-line: assert rst_n=0 one cycle after a qualifying beat → data_out=0 and data_out_valid=0 immediately, and the pending output is never emitted. After release, sol plus 4 beats give no output, and beat 5 gives an output.
